inst_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the instruction decoder. It holds the fetch PC and issues requests on an SRAM-like instruction bus that supports multiple outstanding requests. Fetched words are buffered in a small in-order queue together with their PC and a fetch-address-error flag, and presented to decode through a valid/stall handshake. It also applies branch/jump redirects and exception/ERET flushes.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/inst_fetch_unit.sv | 138 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR       = 32'hBFC0_0380;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO; push is accepted when full only if a pop happens in the same cycle.
module fetch_fifo #(
    parameter type T = logic [31:0],
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch PC, multi-outstanding instruction bus requests, in-order buffer to decode.
// Optional FETCH_PERF_EN adds stall-cycle and dropped-response counters.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    input  logic        stallD,
    output logic        validD,
    output logic [31:0] instD,
    output logic [31:0] pcD,
    output logic        adelD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_discard_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state, state_next;
    logic [31:0]   pc_f, pc_next;
    logic [CW-1:0] discard, discard_next;
    logic [CW-1:0] inflight, buf_count;
    logic [CW:0]   occupancy;
    logic          pend_full, pend_empty, buf_full, buf_empty;
    logic [31:0]   pend_head;
    fetch_entry_t  buf_head, buf_push_data;
    logic          redirect_any, aligned, accept, resp_pop, resp_keep, mis_push;
    logic          buf_push, buf_pop;
    logic [31:0]   target;

    assign redirect_any = flush_valid || redirect_valid;
    assign target       = flush_valid ? flush_pc : redirect_pc;
    assign aligned      = (pc_f[1:0] == 2'b00);
    assign occupancy    = {1'b0, inflight} + {1'b0, buf_count};

    assign inst_req  = resetn && (state == FETCH_RUN) && aligned && !pend_full
                    && (occupancy < (CW + 1)'(DEPTH)) && !redirect_any;
    assign inst_addr = pc_f;
    assign accept    = inst_req && inst_addr_ok;

    // A response arriving in a redirect cycle belongs to the old stream.
    assign resp_pop  = inst_data_ok && !pend_empty;
    assign resp_keep = resp_pop && (discard == '0) && !redirect_any;
    assign mis_push  = (state == FETCH_RUN) && !aligned && (inflight == '0)
                    && !buf_full && !redirect_any;

    assign buf_push      = resp_keep || mis_push;
    assign buf_push_data = mis_push ? '{pc: pc_f, inst: 32'h0, adel: 1'b1}
                                    : '{pc: pend_head, inst: inst_rdata, adel: 1'b0};
    assign buf_pop       = validD && !stallD;

    assign validD = !buf_empty;
    assign instD  = buf_empty ? 32'h0 : buf_head.inst;
    assign pcD    = buf_empty ? 32'h0 : buf_head.pc;
    assign adelD  = buf_empty ? 1'b0  : buf_head.adel;

    always_comb begin
        state_next   = state;
        pc_next      = pc_f;
        discard_next = discard;
        if (redirect_any) begin
            state_next   = FETCH_RUN;
            pc_next      = target;
            // Everything still outstanding after this cycle is stale.
            discard_next = inflight - CW'(resp_pop);
        end else begin
            if (mis_push) state_next = FETCH_HALT;
            if (accept)   pc_next    = pc_f + 32'd4;
            if (resp_pop && discard != '0) discard_next = discard - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= FETCH_RUN;
            pc_f    <= RESET_PC;
            discard <= '0;
        end else begin
            state   <= state_next;
            pc_f    <= pc_next;
            discard <= discard_next;
        end
    end

    fetch_fifo #(.T(logic [31:0]), .DEPTH(DEPTH)) u_pending (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (1'b0),
        .push      (accept),
        .push_data (pc_f),
        .pop       (resp_pop),
        .head      (pend_head),
        .full      (pend_full),
        .empty     (pend_empty),
        .count     (inflight)
    );

    fetch_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_buffer (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (redirect_any),
        .push      (buf_push),
        .push_data (buf_push_data),
        .pop       (buf_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_cnt   <= 32'h0;
            perf_discard_cnt <= 32'h0;
        end else begin
            if (validD && stallD) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (resp_pop && !resp_keep) perf_discard_cnt <= perf_discard_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a one-cycle-latency in-order bus responder.
module tb_inst_fetch_unit;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        stallD;
    logic        validD;
    logic [31:0] instD;
    logic [31:0] pcD;
    logic        adelD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_discard_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic        resp_en;
    logic [31:0] resp_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] out_q[$];
    logic [31:0] ins_q[$];

    inst_fetch_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_valid    (flush_valid),
        .flush_pc       (flush_pc),
        .stallD         (stallD),
        .validD         (validD),
        .instD          (instD),
        .pcD            (pcD),
        .adelD          (adelD)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_discard_cnt (perf_discard_cnt)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus responder: returns ~addr one cycle after acceptance, in order.
    initial begin
        logic        hs;
        logic        dk;
        logic [31:0] ha;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            hs = inst_req && inst_addr_ok;
            ha = inst_addr;
            dk = inst_data_ok;
            @(posedge clk);
            #1;
            if (!resetn) begin
                resp_q.delete();
            end else begin
                if (dk) void'(resp_q.pop_front());
                if (hs) resp_q.push_back(ha);
            end
            if (resetn && resp_en && resp_q.size() > 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = ~resp_q[0];
            end else begin
                inst_data_ok = 1'b0;
                inst_rdata   = 32'h0;
            end
        end
    end

    // Monitor: accepted request addresses and instructions consumed by decode.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (inst_req && inst_addr_ok) acc_q.push_back(inst_addr);
                if (validD && !stallD) begin
                    out_q.push_back(pcD);
                    ins_q.push_back(instD);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic reset_hold();
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        flush_valid    = 1'b0;
        redirect_pc    = 32'h0;
        flush_pc       = 32'h0;
        cyc();
        cyc();
        acc_q.delete();
        out_q.delete();
        ins_q.delete();
    endtask

    // Directed stimulus
    initial begin
        resetn       = 1'b0;
        inst_addr_ok = 1'b0;
        stallD       = 1'b0;
        resp_en      = 1'b1;

        // Reset state
        reset_hold();
        settle();
        chk("rst_validD", {31'h0, validD}, 32'h0);
        chk("rst_inst_req", {31'h0, inst_req}, 32'h0);
        chk("rst_instD", instD, 32'h0);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_adelD", {31'h0, adelD}, 32'h0);
        chk("rst_addr", inst_addr, 32'hBFC0_0000);

        // Sequential fetch
        inst_addr_ok = 1'b1;
        resetn = 1'b1;
        settle();
        chk("seq_req0", {31'h0, inst_req}, 32'h1);
        chk("seq_addr0", inst_addr, 32'hBFC0_0000);
        cyc(); settle();
        chk("seq_valid_b", {31'h0, validD}, 32'h0);
        chk("seq_addr1", inst_addr, 32'hBFC0_0004);
        cyc(); settle();
        chk("seq_valid_c", {31'h0, validD}, 32'h1);
        chk("seq_pcD_c", pcD, 32'hBFC0_0000);
        chk("seq_instD_c", instD, 32'h403F_FFFF);
        chk("seq_req_full", {31'h0, inst_req}, 32'h0);
        run(12);
        chk("seq_acc_n", {31'h0, acc_q.size() >= 3}, 32'h1);
        chk("seq_out_n", {31'h0, out_q.size() >= 3}, 32'h1);
        if (acc_q.size() >= 3 && out_q.size() >= 3) begin
            chk("seq_acc2", acc_q[2], 32'hBFC0_0008);
            chk("seq_out0", out_q[0], 32'hBFC0_0000);
            chk("seq_out1", out_q[1], 32'hBFC0_0004);
            chk("seq_out2", out_q[2], 32'hBFC0_0008);
            chk("seq_ins2", ins_q[2], 32'h403F_FFF7);
        end

        // Decode stall limits outstanding work to DEPTH
        reset_hold();
        stallD = 1'b1;
        inst_addr_ok = 1'b1;
        resetn = 1'b1;
        run(10); settle();
        chk("stall_acc_n", acc_q.size(), 32'd2);
        chk("stall_req", {31'h0, inst_req}, 32'h0);
        chk("stall_validD", {31'h0, validD}, 32'h1);
        chk("stall_pcD", pcD, 32'hBFC0_0000);
        stallD = 1'b0;
        run(8);
        chk("stall_resume_n", {31'h0, acc_q.size() >= 3}, 32'h1);
        if (acc_q.size() >= 3) chk("stall_resume_addr", acc_q[2], 32'hBFC0_0008);

        // Redirect with two requests in flight
        reset_hold();
        resp_en = 1'b0;
        stallD = 1'b0;
        inst_addr_ok = 1'b1;
        resetn = 1'b1;
        cyc(); cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'hBFC0_0100;
        settle();
        chk("redir_req", {31'h0, inst_req}, 32'h0);
        cyc();
        redirect_valid = 1'b0;
        resp_en = 1'b1;
        settle();
        chk("redir_addr", inst_addr, 32'hBFC0_0100);
        chk("redir_validD", {31'h0, validD}, 32'h0);
        run(10);
        chk("redir_out_n", {31'h0, out_q.size() >= 1}, 32'h1);
        if (out_q.size() >= 1) begin
            chk("redir_out0", out_q[0], 32'hBFC0_0100);
            chk("redir_ins0", ins_q[0], 32'h403F_FEFF);
        end
        chk("redir_acc2", (acc_q.size() >= 3) ? acc_q[2] : 32'hDEAD_DEAD, 32'hBFC0_0100);
`ifdef FETCH_PERF_EN
        chk("perf_discard", perf_discard_cnt, 32'd2);
`endif

        // Misaligned redirect, then flush recovers
        reset_hold();
        inst_addr_ok = 1'b0;
        stallD = 1'b1;
        resetn = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0002;
        settle();
        chk("mis_req_a", {31'h0, inst_req}, 32'h0);
        cyc();
        redirect_valid = 1'b0;
        settle();
        chk("mis_req_b", {31'h0, inst_req}, 32'h0);
        cyc(); settle();
        chk("mis_validD", {31'h0, validD}, 32'h1);
        chk("mis_pcD", pcD, 32'h8000_0002);
        chk("mis_instD", instD, 32'h0);
        chk("mis_adelD", {31'h0, adelD}, 32'h1);
        chk("mis_req_c", {31'h0, inst_req}, 32'h0);
        cyc();
        flush_valid = 1'b1;
        flush_pc = 32'hBFC0_0380;
        stallD = 1'b0;
        inst_addr_ok = 1'b1;
        settle();
        chk("mis_flush_req", {31'h0, inst_req}, 32'h0);
        cyc();
        flush_valid = 1'b0;
        settle();
        chk("mis_resume_req", {31'h0, inst_req}, 32'h1);
        chk("mis_resume_addr", inst_addr, 32'hBFC0_0380);
        chk("mis_resume_validD", {31'h0, validD}, 32'h0);

        // Flush wins over simultaneous redirect
        reset_hold();
        inst_addr_ok = 1'b0;
        resetn = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hBFC0_0200;
        flush_valid = 1'b1;
        flush_pc = 32'hBFC0_0380;
        settle();
        chk("prio_req", {31'h0, inst_req}, 32'h0);
        cyc();
        redirect_valid = 1'b0;
        flush_valid = 1'b0;
        settle();
        chk("prio_addr", inst_addr, 32'hBFC0_0380);
        chk("prio_req_next", {31'h0, inst_req}, 32'h1);

        // PC wraps from 0xFFFF_FFFC to 0
        reset_hold();
        inst_addr_ok = 1'b0;
        resetn = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        inst_addr_ok = 1'b1;
        settle();
        chk("wrap_addr0", inst_addr, 32'hFFFF_FFFC);
        cyc(); settle();
        chk("wrap_addr1", inst_addr, 32'h0000_0000);

        // Reset mid-stream with a full buffer
        reset_hold();
        stallD = 1'b1;
        inst_addr_ok = 1'b1;
        resetn = 1'b1;
        run(6); settle();
        chk("mid_validD_pre", {31'h0, validD}, 32'h1);
        chk("mid_pcD_pre", pcD, 32'hBFC0_0000);
        resetn = 1'b0;
        settle();
        chk("mid_validD_rst", {31'h0, validD}, 32'h0);
        chk("mid_req_rst", {31'h0, inst_req}, 32'h0);
        chk("mid_pcD_rst", pcD, 32'h0);
        cyc();
        stallD = 1'b0;
        resetn = 1'b1;
        settle();
        chk("mid_req_rel", {31'h0, inst_req}, 32'h1);
        chk("mid_addr_rel", inst_addr, 32'hBFC0_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
